// File: rtl/uart_core_ext.sv
// UART core: programmable baud divisor and frame format, TX/RX FIFOs,
// sticky line-error flags with write-one-to-clear, and a level interrupt.
module uart_core_ext #(
  parameter int FIFO_ADDR_W = 4,
  parameter int DVSR_W      = 11
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        read,
  input  logic        write,
  input  logic [4:0]  reg_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        tx,
  input  logic        rx,
  output logic        irq
);
  localparam int DEPTH = 2 ** FIFO_ADDR_W;
  localparam logic [FIFO_ADDR_W:0] PTR_ONE = 1;
  localparam logic [DVSR_W-1:0]    DV_ONE  = 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [18:0]        r_ctrl;
  logic [2:0]         r_err;
  logic [DVSR_W-1:0]  r_tick_cnt;
  logic [7:0]         r_tx_mem [DEPTH];
  logic [7:0]         r_rx_mem [DEPTH];
  logic [FIFO_ADDR_W:0] r_tx_wptr, r_tx_rptr, r_rx_wptr, r_rx_rptr;
  state_t             r_tx_state, w_tx_state_next, r_rx_state, w_rx_state_next;
  logic [4:0]         r_tx_cnt;
  logic [2:0]         r_tx_bitn;
  logic [7:0]         r_tx_shift;
  logic               r_tx_par, r_tx_stop2, r_tx_data8;
  logic [1:0]         r_tx_pmode;
  logic [1:0]         r_rx_sync;
  logic               r_rx_prev, r_rx_perr, r_rx_data8;
  logic [3:0]         r_rx_cnt;
  logic [2:0]         r_rx_bitn;
  logic [7:0]         r_rx_shift;
  logic [1:0]         r_rx_pmode;

  logic w_wr_ctrl, w_wr_status, w_wr_tx, w_tick;
  logic w_tx_empty, w_tx_full, w_tx_push, w_tx_load, w_tx_bit_end, w_tx_stop_end, w_tx_last, w_tx_idle;
  logic w_rx_empty, w_rx_full, w_rx_pop, w_rx_push, w_rx_line, w_rx_fall, w_rx_sample, w_rx_last, w_rx_done;
  logic [7:0] w_tx_head, w_rx_head, w_rx_byte;
  logic [FIFO_ADDR_W:0] w_rx_level;
  logic [2:0] w_err_set;
  logic w_unused;

  assign w_wr_ctrl   = cs && write && (reg_addr == 5'd0);
  assign w_wr_status = cs && write && (reg_addr == 5'd1);
  assign w_wr_tx     = cs && write && (reg_addr == 5'd3);
  assign w_rx_pop    = cs && read  && (reg_addr == 5'd2) && !w_rx_empty;
  assign w_unused    = ^wr_data[31:19];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_ctrl <= '0;
    else if (w_wr_ctrl) r_ctrl <= wr_data[18:0] & 19'h7BFFF;
  end

  assign w_tick = (r_tick_cnt == r_ctrl[DVSR_W-1:0]);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_tick_cnt <= '0;
    else if (w_wr_ctrl || w_tick) r_tick_cnt <= '0;
    else r_tick_cnt <= r_tick_cnt + DV_ONE;
  end

  // FIFOs: the extra pointer MSB separates full from empty when indices match
  assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
  assign w_tx_full  = (r_tx_wptr[FIFO_ADDR_W] != r_tx_rptr[FIFO_ADDR_W]) &&
                      (r_tx_wptr[FIFO_ADDR_W-1:0] == r_tx_rptr[FIFO_ADDR_W-1:0]);
  assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
  assign w_rx_full  = (r_rx_wptr[FIFO_ADDR_W] != r_rx_rptr[FIFO_ADDR_W]) &&
                      (r_rx_wptr[FIFO_ADDR_W-1:0] == r_rx_rptr[FIFO_ADDR_W-1:0]);
  assign w_tx_head  = r_tx_mem[r_tx_rptr[FIFO_ADDR_W-1:0]];
  assign w_rx_head  = r_rx_mem[r_rx_rptr[FIFO_ADDR_W-1:0]];
  assign w_rx_level = r_rx_wptr - r_rx_rptr;
  assign w_tx_push  = w_wr_tx && !w_tx_full;

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wptr[FIFO_ADDR_W-1:0]] <= wr_data[7:0];
    if (w_rx_push) r_rx_mem[r_rx_wptr[FIFO_ADDR_W-1:0]] <= w_rx_byte;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_wptr <= '0; r_tx_rptr <= '0; r_rx_wptr <= '0; r_rx_rptr <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + PTR_ONE;
      if (w_tx_load) r_tx_rptr <= r_tx_rptr + PTR_ONE;
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + PTR_ONE;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + PTR_ONE;
    end
  end

  // ---------------- transmitter ----------------
  assign w_tx_bit_end  = w_tick && (r_tx_cnt == 5'd15);
  assign w_tx_stop_end = w_tick && (r_tx_cnt == (r_tx_stop2 ? 5'd31 : 5'd15));
  assign w_tx_last     = (r_tx_bitn == (r_tx_data8 ? 3'd7 : 3'd6));
  assign w_tx_load     = w_tick && !w_tx_empty &&
                         ((r_tx_state == S_IDLE) || ((r_tx_state == S_STOP) && w_tx_stop_end));
  assign w_tx_idle     = w_tx_empty && (r_tx_state == S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_tx_state <= S_IDLE;
    else r_tx_state <= w_tx_state_next;
  end

  always_comb begin
    w_tx_state_next = r_tx_state;
    case (r_tx_state)
      S_IDLE:   if (w_tx_load) w_tx_state_next = S_START;
      S_START:  if (w_tx_bit_end) w_tx_state_next = S_DATA;
      S_DATA:   if (w_tx_bit_end && w_tx_last)
                  w_tx_state_next = (r_tx_pmode == 2'b01 || r_tx_pmode == 2'b10) ? S_PARITY : S_STOP;
      S_PARITY: if (w_tx_bit_end) w_tx_state_next = S_STOP;
      S_STOP:   if (w_tx_stop_end) w_tx_state_next = w_tx_load ? S_START : S_IDLE;
      default:  w_tx_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (r_tx_state)
      S_START:  tx = 1'b0;
      S_DATA:   tx = r_tx_shift[0];
      S_PARITY: tx = r_tx_par;
      default:  tx = 1'b1;
    endcase
  end

  // Frame format is captured with the byte so CTRL writes only affect later frames
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_cnt <= '0; r_tx_bitn <= '0; r_tx_shift <= '0; r_tx_par <= 1'b0;
      r_tx_stop2 <= 1'b0; r_tx_data8 <= 1'b0; r_tx_pmode <= '0;
    end else if (w_tx_load) begin
      r_tx_cnt   <= '0;
      r_tx_bitn  <= '0;
      r_tx_shift <= w_tx_head;
      r_tx_par   <= (^(w_tx_head & {r_ctrl[15], 7'h7F})) ^ (r_ctrl[12:11] == 2'b10);
      r_tx_pmode <= r_ctrl[12:11];
      r_tx_stop2 <= r_ctrl[13];
      r_tx_data8 <= r_ctrl[15];
    end else if (w_tick && r_tx_state != S_IDLE) begin
      r_tx_cnt <= (w_tx_bit_end && r_tx_state != S_STOP) ? 5'd0 : r_tx_cnt + 5'd1;
      if (r_tx_state == S_DATA && w_tx_bit_end) begin
        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
        r_tx_bitn  <= r_tx_bitn + 3'd1;
      end
    end
  end

  // ---------------- receiver ----------------
  assign w_rx_line   = r_ctrl[16] ? tx : r_rx_sync[1];
  assign w_rx_fall   = r_rx_prev && !w_rx_line;
  assign w_rx_sample = w_tick && (r_rx_cnt == 4'd15);
  assign w_rx_last   = (r_rx_bitn == (r_rx_data8 ? 3'd7 : 3'd6));
  assign w_rx_byte   = r_rx_data8 ? r_rx_shift : {1'b0, r_rx_shift[7:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_state <= S_IDLE; r_rx_sync <= 2'b11; r_rx_prev <= 1'b1;
    end else begin
      r_rx_state <= w_rx_state_next;
      r_rx_sync  <= {r_rx_sync[0], rx};
      r_rx_prev  <= w_rx_line;
    end
  end

  always_comb begin
    w_rx_state_next = r_rx_state;
    case (r_rx_state)
      S_IDLE:   if (w_rx_fall) w_rx_state_next = S_START;
      S_START:  if (w_tick && r_rx_cnt == 4'd7) w_rx_state_next = w_rx_line ? S_IDLE : S_DATA;
      S_DATA:   if (w_rx_sample && w_rx_last)
                  w_rx_state_next = (r_rx_pmode == 2'b01 || r_rx_pmode == 2'b10) ? S_PARITY : S_STOP;
      S_PARITY: if (w_rx_sample) w_rx_state_next = S_STOP;
      S_STOP:   if (w_rx_sample) w_rx_state_next = S_IDLE;
      default:  w_rx_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rx_done = (r_rx_state == S_STOP) && w_rx_sample;
    w_rx_push = w_rx_done && (!w_rx_full || w_rx_pop);
    w_err_set = {w_rx_done && w_rx_full && !w_rx_pop, w_rx_done && !w_rx_line, w_rx_done && r_rx_perr};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_cnt <= '0; r_rx_bitn <= '0; r_rx_shift <= '0; r_rx_perr <= 1'b0;
      r_rx_pmode <= '0; r_rx_data8 <= 1'b0;
    end else if (r_rx_state == S_IDLE) begin
      r_rx_cnt  <= '0;
      r_rx_bitn <= '0;
      r_rx_perr <= 1'b0;
      if (w_rx_fall) begin
        r_rx_pmode <= r_ctrl[12:11];
        r_rx_data8 <= r_ctrl[15];
      end
    end else if (w_tick) begin
      r_rx_cnt <= ((r_rx_state == S_START && r_rx_cnt == 4'd7) || r_rx_cnt == 4'd15) ? 4'd0 : r_rx_cnt + 4'd1;
      if (r_rx_state == S_DATA && r_rx_cnt == 4'd15) begin
        r_rx_shift <= {w_rx_line, r_rx_shift[7:1]};
        r_rx_bitn  <= r_rx_bitn + 3'd1;
      end
      if (r_rx_state == S_PARITY && r_rx_cnt == 4'd15)
        r_rx_perr <= w_rx_line ^ (^w_rx_byte) ^ (r_rx_pmode == 2'b10);
    end
  end

  // A fresh error wins over a simultaneous write-one-to-clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_err <= '0;
    else if (w_wr_status) r_err <= (r_err & ~wr_data[2:0]) | w_err_set;
    else r_err <= r_err | w_err_set;
  end

  assign irq = (r_ctrl[17] && !w_rx_empty) || (r_ctrl[18] && (|r_err));

  always_comb begin
    rd_data = '0;
    case (reg_addr)
      5'd0: rd_data[18:0] = r_ctrl;
      5'd1: rd_data[15:0] = {8'(w_rx_level), 2'b00, w_tx_idle, w_tx_full, w_rx_empty, r_err};
      5'd2: if (!w_rx_empty) rd_data[7:0] = w_rx_head;
      default: rd_data = '0;
    endcase
  end
endmodule

// File: tb/tb_uart_core_ext.sv
// Directed bench for uart_core_ext: TX waveform, loopback, error injection,
// overrun, glitch rejection and reset; expected data flows through scoreboards.
module tb_uart_core_ext;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs = 1'b0, read = 1'b0, write = 1'b0;
  logic [4:0]  reg_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        tx, irq;
  logic        rx = 1'b1;

  int tests = 0;
  int fails = 0;
  logic [7:0] sb[$];
  logic       tx_q[$];

  localparam int BIT_CLK = 64;

  always #5 clk = ~clk;

  uart_core_ext #(.FIFO_ADDR_W(4), .DVSR_W(11)) dut (
    .clk(clk), .reset_n(reset_n), .cs(cs), .read(read), .write(write),
    .reg_addr(reg_addr), .wr_data(wr_data), .rd_data(rd_data),
    .tx(tx), .rx(rx), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    cs = 1'b1; write = 1'b1; reg_addr = a; wr_data = d;
    @(posedge clk); #1;
    cs = 1'b0; write = 1'b0; wr_data = '0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    cs = 1'b1; read = 1'b1; reg_addr = a;
    #1 d = rd_data;
    @(posedge clk); #1;
    cs = 1'b0; read = 1'b0;
  endtask

  task automatic drive_bit(input logic b);
    @(posedge clk); #1 rx = b;
    repeat (BIT_CLK - 1) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input int nbits, input bit par_en,
                            input logic par_bit, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(data[i]);
    if (par_en) drive_bit(par_bit);
    drive_bit(stop_bit);
    drive_bit(1'b1);
  endtask

  task automatic wait_tx_low(input int budget);
    int n = 0;
    while (tx !== 1'b0 && n < budget) begin
      @(posedge clk); #1; n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  v;
    int          n;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1);
    check("rst_irq", irq, 0);
    reg_addr = 5'd1; #1 check("rst_status", rd_data, 32'h28);
    reg_addr = 5'd0; #1 check("rst_ctrl", rd_data, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    bus_write(5'd0, 32'hFFFF_FFFF);
    bus_read(5'd0, d);  check("ctrl_readback", d, 32'h0007_BFFF);
    bus_write(5'd5, 32'h1234);
    bus_read(5'd5, d);  check("unmapped_read", d, 0);
    bus_read(5'd2, d);  check("rd_empty", d, 0);

    // TX waveform of 0xA5, 8N1, dvsr 3 -> 64 clk per bit
    bus_write(5'd0, 32'h8003);
    v = 8'hA5;
    tx_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) tx_q.push_back(v[i]);
    tx_q.push_back(1'b1);
    bus_write(5'd3, {24'h0, v});
    wait_tx_low(100);
    check("tx_start_edge", tx, 0);
    repeat (31) @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      check("tx_bit", tx, tx_q.pop_front());
      if (k < 9) begin repeat (BIT_CLK) @(posedge clk); #1; end
    end
    repeat (21) @(posedge clk); #1;
    reg_addr = 5'd1; #1 check("tx_idle_mid", rd_data[5], 0);
    repeat (20) @(posedge clk); #1;
    reg_addr = 5'd1; #1 check("tx_idle_end", rd_data[5], 1);

    // loopback 8E2, 16 bytes
    bus_write(5'd0, 32'h0001_A803);
    for (int i = 0; i < 16; i++) begin
      bus_write(5'd3, i);
      sb.push_back(8'(i));
    end
    reg_addr = 5'd1; #1;
    n = 0;
    while (rd_data[15:8] !== 8'd16 && n < 16000) begin
      @(posedge clk); #1; n++;
    end
    check("lb_level", rd_data[15:8], 16);
    check("lb_errors", rd_data[2:0], 0);
    for (int i = 0; i < 16; i++) begin
      bus_read(5'd2, d);
      check("lb_data", d, {24'h0, sb.pop_front()});
    end
    bus_read(5'd1, d); check("lb_drained", d[3], 1);

    // parity + frame error injection, 8E1
    bus_write(5'd0, 32'h8803);
    sb.push_back(8'h5A);
    send_frame(8'h5A, 8, 1'b1, 1'b1, 1'b0);
    bus_read(5'd1, d);
    check("err_flags", d[2:0], 3'b011);
    check("err_level", d[15:8], 1);
    bus_read(5'd2, d); check("err_data", d, {24'h0, sb.pop_front()});
    bus_write(5'd1, 32'h3);
    bus_read(5'd1, d); check("err_w1c", d[2:0], 0);

    // overrun with 17 frames, 8N1, error irq enabled
    bus_write(5'd0, 32'h0004_8003);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) sb.push_back(8'h30 + 8'(i));
      send_frame(8'h30 + 8'(i), 8, 1'b0, 1'b0, 1'b1);
    end
    bus_read(5'd1, d);
    check("ovr_flag", d[2:0], 3'b100);
    check("ovr_level", d[15:8], 16);
    check("ovr_irq", irq, 1);
    for (int i = 0; i < 16; i++) begin
      bus_read(5'd2, d);
      check("ovr_data", d, {24'h0, sb.pop_front()});
    end
    bus_read(5'd1, d); check("ovr_last_lost", d[3], 1);
    bus_write(5'd1, 32'h4);
    check("ovr_irq_clr", irq, 0);

    // glitch rejection then 7-bit receive
    bus_write(5'd0, 32'h0003);
    @(posedge clk); #1 rx = 1'b0;
    repeat (12) @(posedge clk);
    #1 rx = 1'b1;
    repeat (200) @(posedge clk);
    bus_read(5'd1, d);
    check("glitch_empty", d[3], 1);
    check("glitch_noerr", d[2:0], 0);
    sb.push_back(8'h7F);
    send_frame(8'hFF, 7, 1'b0, 1'b0, 1'b1);
    bus_read(5'd2, d); check("rx7_data", d, {24'h0, sb.pop_front()});

    // reset in the middle of a TX frame
    bus_write(5'd3, 32'h55);
    wait_tx_low(100);
    check("rst_mid_start", tx, 0);
    repeat (100) @(posedge clk);
    #1 reset_n = 1'b0;
    #1 check("rst_mid_tx", tx, 1);
    reg_addr = 5'd1; #1 check("rst_mid_status", rd_data, 32'h28);
    check("rst_mid_irq", irq, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (5) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
